aes_ct_fifo: RTL and testbench
==============================

Name: aes_ct_fifo

Overview:
- Downstream result buffer for the AES-192 wrapper; consumes the 128-bit ciphertext and its valid level from the aes_192_sed core.
- Captures one entry per valid assertion into a small FIFO, so software can launch back-to-back operations without losing results.
- Exposes a word-addressed register read/write port in the same style as the wrapper's external register bus: ready always 1, error always 0.
- Provides a non-empty interrupt.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ct_i  in  128  ciphertext from AES core
- ct_valid_i  in  1  core valid level; stays high while ct_i is valid
- reglk_i  in  2  bit0 = read lock (reads return 0), bit1 = write lock (CTRL writes ignored)
- addr_i  in  32  bus address; addr_i[4:2] selects the word
- write_i  in  1  bus write strobe, one cycle per access
- wdata_i  in  32  bus write data
- rdata_o  out  32  bus read data, combinational from addr_i
- irq_o  out  1  high while FIFO is non-empty

Behaviour:
- Clock and reset: single clock clk_i; rst_ni asynchronous active-low.
- Reset values:
  - All pointers = 0, count = 0, overflow = 0, ct_valid_q = 0; FIFO storage is not reset.
  - irq_o = 0. rdata_o reads STATUS = 1 (empty) at address 0.
- Capture:
  - ct_valid_q registers ct_valid_i.
  - Capture pulse cap = ct_valid_i & ~ct_valid_q, i.e. a rising edge. A valid held high yields exactly one entry.
  - On cap with FIFO not full: ct_i is written at wr_ptr; wr_ptr increments modulo DEPTH; count increments.
  - Latency: entry visible to reads and irq_o on the cycle after the edge.
  - On cap with FIFO full: entry dropped and overflow set (sticky). Pointers unchanged.
- Pop: a write to CTRL with wdata_i[0] = 1 and reglk_i[1] = 0.
  - Not empty: rd_ptr increments modulo DEPTH; count decrements.
  - Empty: ignored, no underflow flag.
- Simultaneous cap and pop:
  - Not full and not empty: both performed, count unchanged.
  - Full: pop frees a slot, so the capture is accepted, count unchanged, no overflow.
  - Empty: capture only, count = 1.
- Flush (CTRL wdata_i[2] = 1): pointers and count go to 0. Flush wins over a same-cycle cap (capture dropped, overflow unchanged) and over pop.
- Clear overflow (CTRL wdata_i[1] = 1): overflow goes to 0. If a dropping cap occurs in the same cycle, set wins.
- Register map (word index addr_i[4:2]):
  - 0 STATUS (RO): [0] empty, [1] full, [2] overflow, [8 +: CNT_W] count.
  - 1..4 HEAD (RO): head entry ct[31:0], [63:32], [95:64], [127:96]. Reads 0 when empty.
  - 5 CTRL (WO): [0] pop, [1] clear overflow, [2] flush. Reads 0.
  - 6: see Optional Feature.
  - 7: reads 0.
- Writes to any word other than 5 are ignored. reglk_i[0] = 1 forces rdata_o = 0 for all words.
- Reset asserted mid-operation: FIFO is emptied immediately (asynchronous). A ct_valid_i still high at reset release does NOT capture, because ct_valid_q is reloaded from ct_valid_i on the first clock with no capture. This is a decided exception to the rising-edge rule.
- irq_o = (count != 0), registered-state derived, glitch-free.

Optional Feature:
- Macro: AES_CT_FIFO_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter, reset to 0 and wrapping at 2^32-1 to 0, is stored alongside each captured entry.
  - Word 6 returns the head entry's timestamp; it reads 0 when empty or read-locked.
- Undefined: no counter or timestamp storage; word 6 reads 0.

Test Plan:
- Single capture: after reset, raise ct_valid_i for 5 cycles with ct_i = 128'h00112233_44556677_8899AABB_CCDDEEFF. Expect STATUS count = 1, irq_o = 1, word1 = 32'hCCDDEEFF, word4 = 32'h00112233. Pop via CTRL = 1 -> STATUS = 32'h1, irq_o = 0.
- Fill and overflow (DEPTH = 4): 5 valid pulses with ct_i low words 1..5. Expect count = 4, full = 1, overflow = 1. Successive pops return 1,2,3,4; then empty. Write CTRL = 2 -> overflow = 0.
- Full plus simultaneous pop and cap: with 4 entries, issue pop in the same cycle as a rising valid carrying 6. Expect count = 4, overflow = 0, last entry read out = 6.
- Flush versus capture, and pop on empty: flush coincident with a rising valid -> count = 0, irq_o = 0. A pop on empty leaves STATUS = 1.
- Locks: reglk_i = 2'b01 -> all reads 0 with data present. reglk_i = 2'b10 -> pop ignored, count unchanged.
- Reset mid-operation: with 3 entries, pulse rst_ni low asynchronously while ct_valid_i is held high. Expect count = 0 immediately and no capture after release. With AES_CT_FIFO_TIMESTAMP_EN, captures at cycles 10 and 25 read back timestamps differing by 15.

Source files
------------

// File: rtl/aes_ct_fifo.sv
// Ciphertext result FIFO behind the AES-192 core, with a word-addressed register port.
// Define AES_CT_FIFO_TIMESTAMP_EN to tag each entry with a free-running cycle count.
module aes_ct_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [127:0] ct_i,
    input  logic         ct_valid_i,
    input  logic [1:0]   reglk_i,
    input  logic [31:0]  addr_i,
    input  logic         write_i,
    input  logic [31:0]  wdata_i,
    output logic [31:0]  rdata_o,
    output logic         irq_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             overflow, overflow_nxt;
    logic             ct_valid_q;
    logic             armed_q;
    logic             irq_q;
    logic [127:0]     mem [DEPTH];

    logic [2:0] word;
    logic       ctrl_wr, pop_req, clr_req, flush_req;
    logic       cap, empty, full, do_push, do_pop, drop;
    logic [127:0] head;
    logic       unused_bits;

    assign word        = addr_i[4:2];
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i[31:3]};

    assign ctrl_wr   = write_i && (word == 3'd5) && !reglk_i[1];
    assign pop_req   = ctrl_wr && wdata_i[0];
    assign clr_req   = ctrl_wr && wdata_i[1];
    assign flush_req = ctrl_wr && wdata_i[2];

    // armed_q suppresses a capture on the first clock after reset, so a valid
    // level that is already high at release is absorbed rather than captured.
    assign cap   = ct_valid_i && !ct_valid_q && armed_q;
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign do_pop  = pop_req && !empty && !flush_req;
    assign do_push = cap && !flush_req && (!full || do_pop);
    assign drop    = cap && !flush_req && full && !do_pop;

    always_comb begin
        count_nxt = count;
        if (flush_req) begin
            count_nxt = '0;
        end else if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_comb begin
        overflow_nxt = overflow;
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (clr_req) begin
            overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            ct_valid_q <= 1'b0;
            armed_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ct_valid_q <= ct_valid_i;
            armed_q    <= 1'b1;
            count      <= count_nxt;
            overflow   <= overflow_nxt;
            irq_q      <= (count_nxt != '0);
            if (flush_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= ct_i;
    end

    assign head  = mem[rd_ptr];
    assign irq_o = irq_q;

`ifdef AES_CT_FIFO_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) ts_mem[wr_ptr] <= ts_cnt;
    end
`endif

    always_comb begin
        rdata_o = '0;
        if (!reglk_i[0]) begin
            case (word)
                3'd0: begin
                    rdata_o[0]          = empty;
                    rdata_o[1]          = full;
                    rdata_o[2]          = overflow;
                    rdata_o[8 +: CNT_W] = count;
                end
                3'd1: rdata_o = empty ? 32'h0 : head[31:0];
                3'd2: rdata_o = empty ? 32'h0 : head[63:32];
                3'd3: rdata_o = empty ? 32'h0 : head[95:64];
                3'd4: rdata_o = empty ? 32'h0 : head[127:96];
`ifdef AES_CT_FIFO_TIMESTAMP_EN
                3'd6: rdata_o = empty ? 32'h0 : ts_mem[rd_ptr];
`endif
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ct_fifo.sv
// Bench for aes_ct_fifo: directed steps plus random traffic against a queue-based model.
// Honours AES_CT_FIFO_TIMESTAMP_EN the same way as the design.
module tb_aes_ct_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [127:0] ct_i = '0;
    logic         ct_valid_i = 1'b0;
    logic [1:0]   reglk_i = 2'b00;
    logic [31:0]  addr_i = '0;
    logic         write_i = 1'b0;
    logic [31:0]  wdata_i = '0;
    logic [31:0]  rdata_o;
    logic         irq_o;

    always #50 clk_i = ~clk_i;

    aes_ct_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ct_i       (ct_i),
        .ct_valid_i (ct_valid_i),
        .reglk_i    (reglk_i),
        .addr_i     (addr_i),
        .write_i    (write_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .irq_o      (irq_o)
    );

    // Reference model: an ordered list of stored results and their capture times.
    logic [127:0] mq[$];
    logic [31:0]  mts[$];
    bit           m_ovf, m_prev, m_armed;
    logic [31:0]  m_time;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mts.delete();
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_time  = '0;
    endtask

    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] r;
        r = '0;
        if (w == 0) begin
            r[0]          = (mq.size() == 0);
            r[1]          = (mq.size() == DEPTH);
            r[2]          = m_ovf;
            r[8 +: CNT_W] = CNT_W'(mq.size());
        end else if (w >= 1 && w <= 4) begin
            if (mq.size() != 0) r = mq[0][32*(w-1) +: 32];
        end
`ifdef AES_CT_FIFO_TIMESTAMP_EN
        else if (w == 6) begin
            if (mts.size() != 0) r = mts[0];
        end
`endif
        return r;
    endfunction

    // Apply the current inputs to the model, then advance one clock.
    task automatic step();
        bit cap, wr, pop, clr, fl;
        cap = ct_valid_i && !m_prev && m_armed;
        wr  = write_i && (addr_i[4:2] == 3'd5) && !reglk_i[1];
        pop = wr && wdata_i[0];
        clr = wr && wdata_i[1];
        fl  = wr && wdata_i[2];
        if (clr) m_ovf = 1'b0;
        if (fl) begin
            mq.delete();
            mts.delete();
        end else begin
            if (pop && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(mts.pop_front());
            end
            if (cap) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(ct_i);
                    mts.push_back(m_time);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_prev  = ct_valid_i;
        m_armed = 1'b1;
        m_time  = m_time + 32'd1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input int w, output logic [31:0] d);
        addr_i = ($urandom & 32'hFFFF_FFE3) | (32'(w) << 2);
        #1;
        d = rdata_o;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int w = 0; w < 8; w++) begin
            rd(w, d);
            chk($sformatf("%s.w%0d", tag, w), d, reglk_i[0] ? 32'h0 : exp_word(w));
        end
        chk({tag, ".irq"}, {31'b0, irq_o}, {31'b0, mq.size() != 0});
        addr_i = '0;
    endtask

    task automatic ctrl(input logic [31:0] v);
        addr_i  = ($urandom & 32'hFFFF_FFE3) | 32'h14;
        wdata_i = v;
        write_i = 1'b1;
        step();
        write_i = 1'b0;
        wdata_i = '0;
        addr_i  = '0;
    endtask

    task automatic pulse(input logic [127:0] d);
        ct_i       = d;
        ct_valid_i = 1'b1;
        step();
        ct_valid_i = 1'b0;
        step();
    endtask

    function automatic logic [127:0] rnd_ct(input logic [31:0] lo);
        return {$urandom, $urandom, $urandom, lo};
    endfunction

    initial begin
        logic [31:0] d, t1, t2;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        check_all("reset");
        rd(0, d);
        chk("reset.status", d, 32'h1);

        // Single capture with a valid level held for five cycles
        ct_i       = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ct_valid_i = 1'b1;
        step();
        chk("single.latency_irq", {31'b0, irq_o}, 32'h1);
        repeat (4) step();
        ct_valid_i = 1'b0;
        step();
        check_all("single");
        rd(1, d); chk("single.w1", d, 32'hCCDDEEFF);
        rd(4, d); chk("single.w4", d, 32'h00112233);
        rd(0, d); chk("single.status", d, 32'h100);
        ctrl(32'h1);
        rd(0, d); chk("single.popped", d, 32'h1);
        chk("single.irq_off", {31'b0, irq_o}, 32'h0);

        // Fill past capacity
        for (int i = 1; i <= 5; i++) pulse(rnd_ct(32'(i)));
        rd(0, d); chk("fill.status", d, 32'h406);
        check_all("fill");
        for (int i = 1; i <= 4; i++) begin
            rd(1, d); chk($sformatf("fill.pop%0d", i), d, 32'(i));
            ctrl(32'h1);
        end
        rd(0, d); chk("fill.empty_ovf", d, 32'h5);
        ctrl(32'h2);
        rd(0, d); chk("fill.ovf_clr", d, 32'h1);

        // Full with pop and capture in the same cycle
        for (int i = 1; i <= 4; i++) pulse(rnd_ct(32'(10 + i)));
        ct_i       = rnd_ct(32'd6);
        ct_valid_i = 1'b1;
        addr_i     = 32'h14;
        wdata_i    = 32'h1;
        write_i    = 1'b1;
        step();
        write_i    = 1'b0;
        ct_valid_i = 1'b0;
        step();
        rd(0, d); chk("fullpop.status", d, 32'h402);
        check_all("fullpop");
        repeat (3) ctrl(32'h1);
        rd(1, d); chk("fullpop.last", d, 32'h6);
        ctrl(32'h1);

        // Dropping capture coincident with clear overflow: set wins
        for (int i = 1; i <= 4; i++) pulse(rnd_ct($urandom));
        ct_i       = rnd_ct($urandom);
        ct_valid_i = 1'b1;
        addr_i     = 32'h14;
        wdata_i    = 32'h2;
        write_i    = 1'b1;
        step();
        write_i    = 1'b0;
        ct_valid_i = 1'b0;
        step();
        rd(0, d); chk("clrdrop.status", d, 32'h406);
        ctrl(32'h4);
        rd(0, d); chk("clrdrop.flushed", d, 32'h5);
        ctrl(32'h2);

        // Flush beats a same-cycle capture; pop on empty is harmless
        pulse(rnd_ct($urandom));
        pulse(rnd_ct($urandom));
        ct_i       = rnd_ct($urandom);
        ct_valid_i = 1'b1;
        addr_i     = 32'h14;
        wdata_i    = 32'h4;
        write_i    = 1'b1;
        step();
        write_i    = 1'b0;
        ct_valid_i = 1'b0;
        step();
        rd(0, d); chk("flushcap.status", d, 32'h1);
        chk("flushcap.irq", {31'b0, irq_o}, 32'h0);
        ctrl(32'h1);
        rd(0, d); chk("popempty.status", d, 32'h1);

        // Read and write locks
        pulse(rnd_ct($urandom));
        pulse(rnd_ct($urandom));
        reglk_i = 2'b01;
        check_all("rdlock");
        reglk_i = 2'b10;
        ctrl(32'h1);
        ctrl(32'h4);
        reglk_i = 2'b00;
        rd(0, d); chk("wrlock.status", d, 32'h200);
        check_all("wrlock");

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            logic [31:0] wd;
            if ($urandom_range(0, 2) == 0) ct_valid_i = ~ct_valid_i;
            ct_i    = rnd_ct($urandom);
            write_i = ($urandom_range(0, 3) == 0);
            wd      = $urandom;
            if ($urandom_range(0, 15) != 0) wd[2] = 1'b0;
            wdata_i = wd;
            addr_i  = ($urandom & 32'hFFFF_FFE3) |
                      (32'(($urandom_range(0, 3) != 0) ? 5 : $urandom_range(0, 7)) << 2);
            reglk_i = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            step();
            write_i = 1'b0;
            if (it % 10 == 9) check_all($sformatf("rand%0d", it));
        end
        reglk_i    = 2'b00;
        ct_valid_i = 1'b0;
        step();

        // Asynchronous reset mid-operation with valid held high
        ctrl(32'h4);
        ctrl(32'h2);
        for (int i = 0; i < 3; i++) pulse(rnd_ct($urandom));
        rd(0, d); chk("rst.pre_status", d, 32'h300);
        ct_i       = rnd_ct($urandom);
        ct_valid_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        rd(0, d); chk("rst.async_status", d, 32'h1);
        chk("rst.async_irq", {31'b0, irq_o}, 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (3) step();
        check_all("rst.release");
        ct_valid_i = 1'b0;
        step();
        pulse(rnd_ct($urandom));
        check_all("rst.recapture");
        rd(0, d); chk("rst.recapture_status", d, 32'h100);

`ifdef AES_CT_FIFO_TIMESTAMP_EN
        ctrl(32'h4);
        pulse(rnd_ct($urandom));
        repeat (13) step();
        pulse(rnd_ct($urandom));
        check_all("ts");
        rd(6, t1);
        ctrl(32'h1);
        rd(6, t2);
        chk("ts.diff", t2 - t1, 32'd15);
`else
        rd(6, t1);
        t2 = t1;
        chk("ts.absent_w6", t2, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
